// File: rtl/reg8_piso_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), WIDTH data bits, stop bit (1),
// each bit held DIV clocks. All outputs come straight from flops.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | line high, Ready=1, waiting for an EN strobe
// S_START | line low for DIV clocks
// S_DATA  | current data bit on the line, DIV clocks per bit
// S_STOP  | line high for DIV clocks, Done follows in IDLE
module reg8_piso_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic [WIDTH-1:0] Reg_In,
    output logic             Ser_Out,
    output logic             Ready,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam int DW = $clog2(DIV + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DW-1:0]    div_q, div_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ser_q, ser_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            ser_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bit_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_START;
                    shreg_d = Reg_In;
                    div_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    div_d   = '0;
                    idx_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (MSB_FIRST != 0) shreg_d = shreg_q << 1;
                    else                shreg_d = shreg_q >> 1;
                    // Index parks on its last value rather than wrapping.
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with state_q.
    always_comb begin
        ser_d   = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_START: ser_d = 1'b0;
            S_DATA:  ser_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
            default: ser_d = 1'b1;
        endcase
    end

    assign Ser_Out = ser_q;
    assign Ready   = ready_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_reg8_piso_tx.sv
// Directed bench for reg8_piso_tx: an LSB-first DIV=1 instance and an MSB-first DIV=3 instance
// driven from hand-computed serial frames.
module tb_reg8_piso_tx;

    logic       clk = 1'b0;
    logic       res;
    logic       en1, en2;
    logic [7:0] din1, din2;
    logic       so1, rdy1, bsy1, dn1;
    logic       so2, rdy2, bsy2, dn2;
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    reg8_piso_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .res(res), .EN(en1), .Reg_In(din1),
        .Ser_Out(so1), .Ready(rdy1), .Busy(bsy1), .Done(dn1)
    );

    reg8_piso_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .res(res), .EN(en2), .Reg_In(din2),
        .Ser_Out(so2), .Ready(rdy2), .Busy(bsy2), .Done(dn2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, " ser"},   32'(so1),  1);
        chk({tag, " ready"}, 32'(rdy1), 1);
        chk({tag, " busy"},  32'(bsy1), 0);
        chk({tag, " done"},  32'(dn1),  0);
    endtask

    // One DIV=1 frame; optionally strobe EN with 8'hFF in cycle 4 of the frame.
    task automatic frame1(input string tag, input logic [7:0] d, input bit poke);
        logic exp_bit;
        en1 = 1'b1; din1 = d;
        step();
        en1 = 1'b0; din1 = 8'h3C;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1)       exp_bit = 1'b0;
            else if (c == 10) exp_bit = 1'b1;
            else              exp_bit = d[c-2];
            chk($sformatf("%s c%0d ser", tag, c),   32'(so1),  32'(exp_bit));
            chk($sformatf("%s c%0d busy", tag, c),  32'(bsy1), 1);
            chk($sformatf("%s c%0d ready", tag, c), 32'(rdy1), 0);
            chk($sformatf("%s c%0d done", tag, c),  32'(dn1),  0);
            if (poke && c == 4) begin en1 = 1'b1; din1 = 8'hFF; end
            if (poke && c == 5) begin en1 = 1'b0; din1 = 8'h3C; end
            step();
        end
        chk({tag, " c11 done"},  32'(dn1),  1);
        chk({tag, " c11 ready"}, 32'(rdy1), 1);
        chk({tag, " c11 ser"},   32'(so1),  1);
        chk({tag, " c11 busy"},  32'(bsy1), 0);
        step();
        chk_idle1({tag, " c12"});
    endtask

    initial begin
        logic exp_bit;
        int   p;
        en1 = 1'b0; en2 = 1'b0; din1 = 8'h00; din2 = 8'h00;

        // 1: reset
        res = 1'b1;
        #2;
        chk_idle1("rst hold");
        #2;
        res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle1($sformatf("rst idle%0d", i));
            chk("rst dut2 ready", 32'(rdy2), 1);
            chk("rst dut2 ser",   32'(so2),  1);
        end

        // 2: single frame of 8'h77
        frame1("f77", 8'h77, 1'b0);

        // 3: EN during the frame is ignored
        frame1("ign", 8'h77, 1'b1);
        step();
        chk_idle1("ign after");

        // 4: back-to-back frames of 8'hA5 with EN held high
        en1 = 1'b1; din1 = 8'hA5;
        step();
        for (int c = 1; c <= 33; c++) begin
            p = ((c - 1) % 11) + 1;
            if (p == 1)       exp_bit = 1'b0;
            else if (p >= 10) exp_bit = 1'b1;
            else              exp_bit = din1[p-2];
            chk($sformatf("b2b c%0d ser", c),  32'(so1), 32'(exp_bit));
            chk($sformatf("b2b c%0d done", c), 32'(dn1), (p == 11) ? 1 : 0);
            chk($sformatf("b2b c%0d busy", c), 32'(bsy1), (p == 11) ? 0 : 1);
            if (c == 33) en1 = 1'b0;
            step();
        end
        chk_idle1("b2b end");

        // 5: mid-frame reset during data bit 3 of 8'h00
        en1 = 1'b1; din1 = 8'h00;
        step();
        en1 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid bit3 ser", 32'(so1), 0);
        chk("mid bit3 busy", 32'(bsy1), 1);
        #1 res = 1'b1;
        #1;
        chk("mid async ser",   32'(so1),  1);
        chk("mid async ready", 32'(rdy1), 1);
        chk("mid async busy",  32'(bsy1), 0);
        #1 res = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_idle1($sformatf("mid post%0d", i));
        end
        frame1("mid clean", 8'h00, 1'b0);

        // 6: DIV=3, MSB first, 8'h80
        en2 = 1'b1; din2 = 8'h80;
        step();
        en2 = 1'b0; din2 = 8'h00;
        for (int c = 1; c <= 30; c++) begin
            if (c <= 3)       exp_bit = 1'b0;
            else if (c <= 6)  exp_bit = 1'b1;
            else if (c <= 27) exp_bit = 1'b0;
            else              exp_bit = 1'b1;
            chk($sformatf("d3 c%0d ser", c),  32'(so2),  32'(exp_bit));
            chk($sformatf("d3 c%0d busy", c), 32'(bsy2), 1);
            chk($sformatf("d3 c%0d done", c), 32'(dn2),  0);
            step();
        end
        chk("d3 c31 done",  32'(dn2),  1);
        chk("d3 c31 ready", 32'(rdy2), 1);
        chk("d3 c31 ser",   32'(so2),  1);
        step();
        chk("d3 c32 done",  32'(dn2),  0);
        chk("d3 c32 ready", 32'(rdy2), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
